// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if
//   Groups the fetcher port of the memory controller and the decoder handshake
//   used by inst_fetch_queue.
//   master : the fetch queue (issues burst requests, presents queued instructions)
//   slave  : the surrounding logic (memory controller, redirect source, decoder)
//   Memory side : mem_enable_out, mem_addr_out, mem_reset_out, mem_avail_in,
//                 mem_word_in, mem_inst_in, mem_end_in
//   Redirect    : jump_in, jump_pc_in
//   Decoder     : inst_valid_out, inst_out, pc_out, inst_ready_in, count_out
interface inst_fetch_queue_if #(
  parameter int QUEUE_DEPTH = 16
) ();
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic          mem_enable_out;
  logic [31:0]   mem_addr_out;
  logic          mem_reset_out;
  logic          mem_avail_in;
  logic          mem_word_in;
  logic [31:0]   mem_inst_in;
  logic          mem_end_in;
  logic          jump_in;
  logic [31:0]   jump_pc_in;
  logic          inst_valid_out;
  logic [31:0]   inst_out;
  logic [31:0]   pc_out;
  logic          inst_ready_in;
  logic [CW-1:0] count_out;

  modport master (
    output mem_enable_out, mem_addr_out, mem_reset_out,
    input  mem_avail_in, mem_word_in, mem_inst_in, mem_end_in,
    input  jump_in, jump_pc_in,
    output inst_valid_out, inst_out, pc_out, count_out,
    input  inst_ready_in
  );

  modport slave (
    input  mem_enable_out, mem_addr_out, mem_reset_out,
    output mem_avail_in, mem_word_in, mem_inst_in, mem_end_in,
    output jump_in, jump_pc_in,
    input  inst_valid_out, inst_out, pc_out, count_out,
    output inst_ready_in
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
//   Issues burst instruction reads to the memory controller, captures each
//   returned word with its PC into a circular queue and hands the queue head to
//   the decoder over valid/ready. A redirect flushes the queue, aborts any burst
//   in flight and restarts fetching at the new PC.
// Ports
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous reset, active low
//   rdy_in  : global ready; while low every register holds
//   bus     : inst_fetch_queue_if.master (memory port, redirect, decoder side)
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for room for a whole burst and an available controller
// S_REQ   | request raised, waiting for the first word
// S_RECV  | capturing words until the controller signals burst end
// S_GAP   | request held low one cycle so the controller can drop avail
// S_ABORT | burst cancelled by a redirect, draining until controller is done
module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH = 16,
  parameter int          BURST_LEN   = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  inst_fetch_queue_if.master bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int KW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] FULL      = CW'(QUEUE_DEPTH);
  localparam logic [CW-1:0] START_MAX = CW'(QUEUE_DEPTH - BURST_LEN);
  localparam logic [KW-1:0] BURST_K   = KW'(BURST_LEN);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RECV, S_GAP, S_ABORT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   mem_addr;
  logic          mem_enable, enable_nxt;
  logic          mem_reset, reset_nxt;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [KW-1:0] words_left;
  logic          do_push, do_pop, do_flush, req_start;
  logic          head_valid;
  logic [31:0]   inst_q [QUEUE_DEPTH];
  logic [31:0]   pc_q   [QUEUE_DEPTH];

  assign head_valid = (count != '0);
  assign do_pop     = head_valid && bus.inst_ready_in && !bus.jump_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in)     state <= S_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    enable_nxt = mem_enable;
    reset_nxt  = 1'b0;
    do_push    = 1'b0;
    do_flush   = 1'b0;
    req_start  = 1'b0;
    if (bus.jump_in) begin
      case (state)
        S_IDLE, S_GAP: begin
          state_nxt = S_IDLE;
          do_flush  = 1'b1;
          reset_nxt = 1'b1;
        end
        S_REQ, S_RECV: begin
          state_nxt  = S_ABORT;
          enable_nxt = 1'b0;
          do_flush   = 1'b1;
          reset_nxt  = 1'b1;
        end
        default: ;  // already aborting: only the fetch PC moves
      endcase
    end else begin
      case (state)
        S_IDLE: begin
          // reserve room for the whole burst up front so a push never finds the queue full
          if (count <= START_MAX && bus.mem_avail_in) begin
            state_nxt  = S_REQ;
            enable_nxt = 1'b1;
            req_start  = 1'b1;
          end
        end
        S_REQ: begin
          if (bus.mem_word_in) begin
            do_push   = 1'b1;
            state_nxt = S_RECV;
          end
        end
        S_RECV: begin
          // words beyond the burst length are dropped
          do_push = bus.mem_word_in && (words_left != '0);
          if (bus.mem_end_in) begin
            state_nxt  = S_GAP;
            enable_nxt = 1'b0;
          end
        end
        S_GAP:   state_nxt = S_IDLE;
        S_ABORT: if (bus.mem_end_in || bus.mem_avail_in) state_nxt = S_GAP;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      fetch_pc   <= RESET_PC;
      mem_addr   <= RESET_PC;
      mem_enable <= 1'b0;
      mem_reset  <= 1'b0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      words_left <= '0;
    end else if (rdy_in) begin
      mem_enable <= enable_nxt;
      mem_reset  <= reset_nxt;
      if (req_start) begin
        mem_addr   <= fetch_pc;
        words_left <= BURST_K;
      end
      if (bus.jump_in) begin
        fetch_pc <= bus.jump_pc_in;
      end else if (do_push) begin
        fetch_pc   <= fetch_pc + 32'd4;
        words_left <= words_left - KW'(1);
      end
      if (do_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + PW'(1);
        if (do_pop)  head <= head + PW'(1);
        count <= count + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && do_push) begin
      inst_q[tail] <= bus.mem_inst_in;
      pc_q[tail]   <= fetch_pc;
    end
  end

  a_push_not_full: assert property (@(posedge clk_in) disable iff (!rst_in)
    (rdy_in && do_push) |-> (count != FULL));

  assign bus.mem_enable_out = mem_enable;
  assign bus.mem_addr_out   = mem_addr;
  assign bus.mem_reset_out  = mem_reset;
  assign bus.inst_valid_out = head_valid;
  // storage is not reset, so an empty queue shows zeros instead of stale data
  assign bus.inst_out       = head_valid ? inst_q[head] : '0;
  assign bus.pc_out         = head_valid ? pc_q[head]   : '0;
  assign bus.count_out      = count;
endmodule
